// File: rtl/wifi_ahb_ctrl_if.sv
// Bus-side bundle between the WiFi AHB slave front-end and wifi_ahb_ctrl.
// Carries the decoded address-phase controls, write/read data and the
// back-pressure/mode bits returned to the front-end.
//   address, wenable, renable, data_trans, HREADY : address-phase controls
//   wifi_hwdata                                   : data-phase write data
//   wifi_hrdata, fifo_full, mode                  : returned to the front-end
interface wifi_ahb_ctrl_if #(
  parameter int ADDR   = 12,
  parameter int DATA_W = 32
);
  logic [ADDR-1:0]   address;
  logic              wenable;
  logic              renable;
  logic [1:0]        data_trans;
  logic              HREADY;
  logic [DATA_W-1:0] wifi_hwdata;
  logic [DATA_W-1:0] wifi_hrdata;
  logic              fifo_full;
  logic              mode;

  modport slave (
    input  address, wenable, renable, data_trans, HREADY, wifi_hwdata,
    output wifi_hrdata, fifo_full, mode
  );

  modport master (
    output address, wenable, renable, data_trans, HREADY, wifi_hwdata,
    input  wifi_hrdata, fifo_full, mode
  );
endinterface

// File: rtl/wifi_ahb_ctrl.sv
// Control/buffer stage behind the WiFi AHB slave front-end.
// Holds CTRL/STATUS/SCRATCH registers, a TX FIFO drained by the PHY
// transmitter and an RX FIFO filled by the PHY receiver.
//   HCLK, HRESET      : clock, async active-high reset
//   bus (slave)       : address/data phase signals, read data, fifo_full, mode
//   tx_data/tx_valid/tx_ready : TX FIFO head towards the PHY
//   rx_data/rx_valid  : RX words from the PHY
//   irq               : RX not empty & rxie, or any sticky overflow flag
module wifi_ahb_ctrl #(
  parameter int ADDR   = 12,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  wifi_ahb_ctrl_if.slave    bus,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_TXD    = 3'd2;
  localparam logic [2:0] A_RXD    = 3'd3;
  localparam logic [2:0] A_SCR    = 3'd4;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ADDR < 5) begin : g_param_check
    $error("wifi_ahb_ctrl: DEPTH must be a power of 2 >= 2 and ADDR >= 5");
  end

  logic [2:0]        addr_q, addr_d;
  logic              wr_q, wr_d, rd_q, rd_d;
  logic [2:0]        ctrl_q, ctrl_d;      // {rxie, stall, en}
  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic              txovf_q, txovf_d, rxovf_q, rxovf_d;
  logic [PW-1:0]     tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [PW-1:0]     rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [DATA_W-1:0] tx_mem_q [DEPTH];
  logic [DATA_W-1:0] rx_mem_q [DEPTH];

  logic [PW-1:0] tx_cnt, rx_cnt;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic wr_ctrl, wr_status, wr_txd, wr_scr, flush;
  logic tx_pop, tx_push, tx_drop, tx_stall;
  logic rx_pop, rx_push, rx_drop;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    tx_cnt   = tx_wp_q - tx_rp_q;
    rx_cnt   = rx_wp_q - rx_rp_q;
    tx_empty = (tx_wp_q == tx_rp_q);
    rx_empty = (rx_wp_q == rx_rp_q);
    tx_full  = (tx_wp_q[PW-1] != tx_rp_q[PW-1]) && (tx_wp_q[PW-2:0] == tx_rp_q[PW-2:0]);
    rx_full  = (rx_wp_q[PW-1] != rx_rp_q[PW-1]) && (rx_wp_q[PW-2:0] == rx_rp_q[PW-2:0]);

    wr_ctrl   = wr_q && (addr_q == A_CTRL);
    wr_status = wr_q && (addr_q == A_STATUS);
    wr_txd    = wr_q && (addr_q == A_TXD);
    wr_scr    = wr_q && (addr_q == A_SCR);
    flush     = wr_ctrl && bus.wifi_hwdata[3];

    tx_valid = !tx_empty && ctrl_q[0];
    tx_data  = tx_mem_q[tx_rp_q[AW-1:0]];
    tx_pop   = tx_valid && tx_ready;
    // A pop in the same cycle frees a slot, so a pending write can land then.
    tx_push  = wr_txd && (!tx_full || tx_pop);
    tx_drop  = wr_txd && tx_full && !tx_pop && !ctrl_q[1];
    tx_stall = wr_txd && tx_full && !tx_pop && ctrl_q[1];

    rx_pop  = rd_q && (addr_q == A_RXD) && !rx_empty;
    rx_push = rx_valid && (!rx_full || rx_pop);
    rx_drop = rx_valid && rx_full && !rx_pop;

    // Address phase; a stalled TX write keeps its data phase open.
    addr_d = addr_q;
    wr_d   = 1'b0;
    rd_d   = 1'b0;
    if (tx_stall) begin
      wr_d = wr_q;
      rd_d = rd_q;
    end else if (bus.HREADY && bus.data_trans[1]) begin
      addr_d = bus.address[4:2];
      wr_d   = bus.wenable;
      rd_d   = bus.renable;
    end

    ctrl_d    = wr_ctrl ? bus.wifi_hwdata[2:0] : ctrl_q;
    scratch_d = wr_scr ? bus.wifi_hwdata : scratch_q;
    // Set wins over a same-cycle W1C clear.
    txovf_d = tx_drop || (txovf_q && !(wr_status && bus.wifi_hwdata[18]));
    rxovf_d = rx_drop || (rxovf_q && !(wr_status && bus.wifi_hwdata[19]));

    tx_wp_d = tx_wp_q + PW'(tx_push);
    tx_rp_d = tx_rp_q + PW'(tx_pop);
    rx_wp_d = rx_wp_q + PW'(rx_push);
    rx_rp_d = rx_rp_q + PW'(rx_pop);
    if (flush) begin
      tx_wp_d = '0;
      tx_rp_d = '0;
      rx_wp_d = '0;
      rx_rp_d = '0;
    end

    rdata = '0;
    if (rd_q) begin
      case (addr_q)
        A_CTRL:   rdata = DATA_W'(ctrl_q);
        A_STATUS: rdata = DATA_W'({12'b0, rxovf_q, txovf_q, rx_empty, tx_full,
                                   8'(rx_cnt), 8'(tx_cnt)});
        A_RXD:    rdata = rx_empty ? '0 : rx_mem_q[rx_rp_q[AW-1:0]];
        A_SCR:    rdata = scratch_q;
        default:  rdata = '0;
      endcase
    end
    bus.wifi_hrdata = rdata;
    bus.fifo_full   = tx_full;
    bus.mode        = ctrl_q[1];
    irq = (!rx_empty && ctrl_q[2]) || txovf_q || rxovf_q;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      addr_q    <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      ctrl_q    <= '0;
      scratch_q <= '0;
      txovf_q   <= 1'b0;
      rxovf_q   <= 1'b0;
      tx_wp_q   <= '0;
      tx_rp_q   <= '0;
      rx_wp_q   <= '0;
      rx_rp_q   <= '0;
    end else begin
      addr_q    <= addr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      scratch_q <= scratch_d;
      txovf_q   <= txovf_d;
      rxovf_q   <= rxovf_d;
      tx_wp_q   <= tx_wp_d;
      tx_rp_q   <= tx_rp_d;
      rx_wp_q   <= rx_wp_d;
      rx_rp_q   <= rx_rp_d;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= '0;
        rx_mem_q[i] <= '0;
      end
    end else begin
      if (tx_push && !flush) tx_mem_q[tx_wp_q[AW-1:0]] <= bus.wifi_hwdata;
      if (rx_push && !flush) rx_mem_q[rx_wp_q[AW-1:0]] <= rx_data;
    end
  end
endmodule

// File: tb/tb_wifi_ahb_ctrl.sv
module tb_wifi_ahb_ctrl;
  localparam int DEPTH = 16;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, irq;

  wifi_ahb_ctrl_if #(.ADDR(12), .DATA_W(32)) bus ();

  wifi_ahb_ctrl #(.ADDR(12), .DEPTH(DEPTH), .DATA_W(32)) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .bus     (bus),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .irq     (irq)
  );

  always #5 HCLK = ~HCLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: register values and FIFO contents as plain queues.
  logic [31:0] tx_q[$];
  logic [31:0] rx_q[$];
  logic [2:0]  m_ctrl;
  logic [31:0] m_scratch;
  logic        m_txovf, m_rxovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    tx_q.delete();
    rx_q.delete();
    m_ctrl = '0;
    m_scratch = '0;
    m_txovf = 1'b0;
    m_rxovf = 1'b0;
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = tx_q.size() + (rx_q.size() * 256);
    if (tx_q.size() == DEPTH) s = s + 32'h0001_0000;
    if (rx_q.size() == 0)     s = s + 32'h0002_0000;
    if (m_txovf)              s = s + 32'h0004_0000;
    if (m_rxovf)              s = s + 32'h0008_0000;
    return s;
  endfunction

  function automatic void model_write(input int off, input logic [31:0] d);
    case (off)
      'h00: begin
        m_ctrl = d[2:0];
        if (d[3]) begin
          tx_q.delete();
          rx_q.delete();
        end
      end
      'h04: begin
        if (d[18]) m_txovf = 1'b0;
        if (d[19]) m_rxovf = 1'b0;
      end
      'h08: if (tx_q.size() < DEPTH) tx_q.push_back(d); else m_txovf = 1'b1;
      'h10: m_scratch = d;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input int off);
    case (off)
      'h00: return {29'b0, m_ctrl};
      'h04: return m_status();
      'h0C: return (rx_q.size() != 0) ? rx_q.pop_front() : 32'h0;
      'h10: return m_scratch;
      default: return 32'h0;
    endcase
  endfunction

  task automatic check_outs(input string tag);
    logic exp_valid;
    logic exp_irq;
    exp_valid = m_ctrl[0] && (tx_q.size() != 0);
    exp_irq   = ((rx_q.size() != 0) && m_ctrl[2]) || m_txovf || m_rxovf;
    chk({tag, ".fifo_full"}, 32'(bus.fifo_full), 32'(tx_q.size() == DEPTH));
    chk({tag, ".mode"},      32'(bus.mode),      32'(m_ctrl[1]));
    chk({tag, ".tx_valid"},  32'(tx_valid),      32'(exp_valid));
    chk({tag, ".irq"},       32'(irq),           32'(exp_irq));
    if (exp_valid) chk({tag, ".tx_data"}, tx_data, tx_q[0]);
  endtask

  task automatic ahb_write(input int off, input logic [31:0] d);
    bus.address = 12'(off); bus.wenable = 1'b1; bus.renable = 1'b0;
    bus.data_trans = 2'b10; bus.HREADY = 1'b1;
    @(posedge HCLK); #1;
    bus.wenable = 1'b0; bus.data_trans = 2'b00; bus.wifi_hwdata = d;
    @(posedge HCLK); #1;
    model_write(off, d);
  endtask

  task automatic ahb_read(input int off, input string tag);
    logic [31:0] exp;
    bus.address = 12'(off); bus.wenable = 1'b0; bus.renable = 1'b1;
    bus.data_trans = 2'b10; bus.HREADY = 1'b1;
    @(posedge HCLK); #1;
    bus.renable = 1'b0; bus.data_trans = 2'b00;
    #1;
    exp = model_read(off);
    chk(tag, bus.wifi_hrdata, exp);
    @(posedge HCLK); #1;
  endtask

  task automatic busy_xfer(input int off, input logic we, input logic re);
    bus.address = 12'(off); bus.wenable = we; bus.renable = re;
    bus.data_trans = 2'b01; bus.HREADY = 1'b1; bus.wifi_hwdata = $urandom;
    @(posedge HCLK); #1;
    bus.wenable = 1'b0; bus.renable = 1'b0; bus.data_trans = 2'b00;
    @(posedge HCLK); #1;
  endtask

  task automatic rx_push(input logic [31:0] d);
    rx_valid = 1'b1; rx_data = d;
    @(posedge HCLK); #1;
    rx_valid = 1'b0;
    if (rx_q.size() < DEPTH) rx_q.push_back(d); else m_rxovf = 1'b1;
  endtask

  task automatic tx_pop_one(input string tag);
    chk({tag, ".tx_data"}, tx_data, tx_q[0]);
    tx_ready = 1'b1;
    @(posedge HCLK); #1;
    tx_ready = 1'b0;
    void'(tx_q.pop_front());
  endtask

  // Leaves a 17th TX_DATA write parked in its data phase (stall mode, FIFO full).
  task automatic start_stalled_write(input logic [31:0] d);
    bus.address = 12'h008; bus.wenable = 1'b1; bus.data_trans = 2'b10; bus.HREADY = 1'b1;
    @(posedge HCLK); #1;
    bus.wenable = 1'b0; bus.data_trans = 2'b00; bus.wifi_hwdata = d; bus.HREADY = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int off;
    logic [31:0] d;

    HRESET = 1'b1;
    bus.address = '0; bus.wenable = 1'b0; bus.renable = 1'b0;
    bus.data_trans = 2'b00; bus.HREADY = 1'b1; bus.wifi_hwdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    model_reset();
    repeat (2) @(posedge HCLK);
    #1 HRESET = 1'b0;

    // Reset state
    chk("reset.hrdata", bus.wifi_hrdata, 32'h0);
    check_outs("reset");
    ahb_read('h04, "reset.status");

    // Stall mode: fill, park a 17th write, release with a single pop
    ahb_write('h00, 32'h3);
    for (int i = 0; i < DEPTH; i++) ahb_write('h08, 32'h100 + i);
    check_outs("stall.filled");
    ahb_read('h04, "stall.status_full");
    start_stalled_write(32'h110);
    repeat (3) @(posedge HCLK);
    #1;
    chk("stall.wr_q_held", 32'(dut.wr_q), 32'h1);
    chk("stall.head", tx_data, 32'h100);
    check_outs("stall.parked");
    tx_pop_one("stall.pop");
    tx_q.push_back(32'h110);
    bus.HREADY = 1'b1;
    chk("stall.wr_q_done", 32'(dut.wr_q), 32'h0);
    check_outs("stall.released");
    ahb_read('h04, "stall.status_after");
    for (int i = 0; i < DEPTH; i++) tx_pop_one("stall.drain");
    check_outs("stall.drained");

    // Drop mode: 17th write is lost and raises txovf
    ahb_write('h00, 32'h1);
    for (int i = 0; i < DEPTH; i++) ahb_write('h08, 32'h200 + i);
    ahb_write('h08, 32'hDEAD);
    check_outs("drop.ovf");
    ahb_read('h04, "drop.status_ovf");
    ahb_write('h04, 32'h0004_0000);
    check_outs("drop.cleared");
    ahb_read('h04, "drop.status_clr");

    // BUSY transfer has no effect, then flush
    busy_xfer('h08, 1'b1, 1'b0);
    rx_push(32'h5555_0000);
    ahb_read('h04, "busy.status");
    ahb_write('h00, 32'h9);
    check_outs("flush");
    ahb_read('h04, "flush.status");
    ahb_read('h00, "flush.ctrl");

    // RX path: ordered reads, empty read returns 0
    ahb_write('h00, 32'h5);
    rx_push(32'hA5A5_0001);
    rx_push(32'hA5A5_0002);
    check_outs("rx.two");
    ahb_read('h0C, "rx.read1");
    ahb_read('h0C, "rx.read2");
    ahb_read('h0C, "rx.read_empty");
    ahb_read('h04, "rx.status_empty");

    // RX overflow
    for (int i = 0; i < DEPTH + 1; i++) rx_push(32'hB000 + i);
    check_outs("rxovf");
    ahb_read('h04, "rxovf.status");
    for (int i = 0; i < DEPTH + 1; i++) ahb_read('h0C, "rxovf.drain");
    ahb_write('h04, 32'h0008_0000);
    check_outs("rxovf.cleared");

    // Scratch and unmapped offsets
    ahb_write('h10, 32'hCAFE_F00D);
    ahb_read('h10, "scratch");
    ahb_write('h14, 32'hFFFF_FFFF);
    ahb_read('h14, "unmapped14");
    ahb_read('h08, "txdata_wo");

    // Randomized traffic against the queue model
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0, 1: begin
          if (tx_q.size() == DEPTH && m_ctrl[1]) begin
            if (m_ctrl[0]) tx_pop_one("rand.pop_room");
          end else begin
            ahb_write('h08, $urandom);
          end
        end
        2: begin
          d = $urandom & 32'hFFFF_FFF7;
          if ($urandom_range(0, 7) == 0) d[3] = 1'b1;
          ahb_write('h00, d);
        end
        3: ahb_write('h04, $urandom);
        4: begin
          off = ($urandom_range(0, 1) == 0) ? 'h10 : (4 * $urandom_range(3, 7));
          ahb_write(off, $urandom);
        end
        5, 6: begin
          off = ($urandom_range(0, 1) == 0) ? 'h0C : (4 * $urandom_range(0, 7));
          ahb_read(off, "rand.read");
        end
        7: rx_push($urandom);
        8: if (m_ctrl[0] && tx_q.size() != 0) tx_pop_one("rand.pop");
        default: busy_xfer(4 * $urandom_range(0, 4), 1'($urandom), 1'($urandom));
      endcase
      check_outs("rand");
    end
    ahb_read('h04, "rand.status_final");

    // Reset in the middle of a stalled write
    ahb_write('h00, 32'hF);
    for (int i = 0; i < DEPTH; i++) ahb_write('h08, 32'h300 + i);
    rx_push(32'h1234_5678);
    start_stalled_write(32'h310);
    @(posedge HCLK);
    #2 HRESET = 1'b1;
    #1;
    model_reset();
    chk("midrst.hrdata", bus.wifi_hrdata, 32'h0);
    chk("midrst.tx_data_valid", 32'(tx_valid), 32'h0);
    check_outs("midrst");
    @(posedge HCLK); #1;
    bus.HREADY = 1'b1;
    HRESET = 1'b0;
    chk("midrst.wr_q", 32'(dut.wr_q), 32'h0);
    ahb_read('h04, "midrst.status");
    ahb_read('h00, "midrst.ctrl");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
